pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 64: payload width (instruction, PC+2, operand data, immediate).
REQ-002 Parameter CTRL_W, default 24: control-bundle width (branch, memRead/memWrite, ALU op, selects, createdump).
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  upstream stage holds a real instruction.
REQ-008 in_ctrl  in  CTRL_W  upstream control bundle.
REQ-009 in_data  in  DATA_W  upstream payload.
REQ-010 stall  in  1  hold current contents (hazard unit).
REQ-011 flush  in  1  squash; insert bubble (branch taken / exception).
REQ-012 out_valid  out  1  registered valid.
REQ-013 out_ctrl  out  CTRL_W  registered control bundle.
REQ-014 out_data  out  DATA_W  registered payload.
REQ-015 stall_cnt  out  CNT_W  stall-cycle count.
REQ-016 flush_cnt  out  CNT_W  flush-event count.

Function
REQ-017 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-018 Latency SHALL be one cycle: inputs sampled at edge N appear on outputs after edge N.
REQ-019 Per-edge priority SHALL be rst > flush > stall > load.
REQ-020 Load (no rst/flush/stall): out_valid<=in_valid, out_data<=in_data, out_ctrl<=in_valid ? in_ctrl : 0.
REQ-021 Stall: out_valid, out_ctrl, out_data SHALL hold their values; in_* ignored.
REQ-022 Flush: out_valid<=0, out_ctrl<=0, out_data holds its value; flush overrides a simultaneous stall.
REQ-023 Invariant: out_valid==0 SHALL imply out_ctrl==0 at every cycle, so a bubble never writes memory, registers, or triggers createdump.
REQ-024 Stalling with out_valid==0 SHALL hold the bubble (stays 0/0).
REQ-025 Back-to-back flush cycles SHALL each produce a bubble; a load on the cycle after flush proceeds normally.

Reset
REQ-026 On rst: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, flush_cnt=0.
REQ-027 rst asserted mid-stall or mid-flush SHALL win; state on the following cycle equals the post-reset state regardless of stall/flush.
REQ-028 Asserting flush or stall during rst SHALL NOT increment the counters.

Configuration
REQ-029 Macro PIPE_STAGE_REG_PERF_CNT_EN SHALL gate the counters.
REQ-030 With the macro defined: stall_cnt increments by 1 on each edge where stall=1, flush=0, rst=0; flush_cnt increments by 1 on each edge where flush=1, rst=0; both saturate at 2^CNT_W-1 with no wrap.
REQ-031 Without the macro: stall_cnt and flush_cnt SHALL be constant 0, no counter flops are instantiated, and pipeline behaviour is identical.

Verification
REQ-032 rst=1 for 2 cycles with in_valid=1, in_ctrl=all-ones -> out_valid=0, out_ctrl=0, out_data=0, counters=0.
REQ-033 Load in_valid=1, in_ctrl=0x00_0A5, in_data=0x1234 -> next cycle out_valid=1, out_ctrl=0x0000A5, out_data=0x1234; in_valid=0 next -> out_ctrl=0, out_data=new in_data.
REQ-034 Load 0x1234, then stall=1 for 3 cycles while in_data=0xBEEF -> outputs stay 0x1234/valid for all 3 cycles; stall_cnt=3 (macro on) or 0 (macro off).
REQ-035 Valid in stage, then stall=1 and flush=1 together -> out_valid=0, out_ctrl=0, out_data unchanged; flush_cnt=1, stall_cnt unchanged.
REQ-036 CNT_W=4, macro on, stall held 20 cycles -> stall_cnt reaches 15 and holds at 15.
REQ-037 Stall=1 with flush=1 and rst=1 on the same edge -> post-reset state; counters remain 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with stall/flush control and optional saturating
// stall/flush event counters (enabled by defining PIPE_STAGE_REG_PERF_CNT_EN).
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;

    // ---- stage p0 -> p1: priority rst > flush > stall > load ----
    // A bubble always carries a zero control bundle so it can never write
    // memory/registers or trigger createdump downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
            ctrl_p1 <= '0;
        end else if (!stall) begin
            vld_p1  <= in_valid;
            ctrl_p1 <= in_valid ? in_ctrl : '0;
            data_p1 <= in_data;
        end
    end

    assign out_valid = vld_p1;
    assign out_ctrl  = ctrl_p1;
    assign out_data  = data_p1;

`ifdef PIPE_STAGE_REG_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_p1;
    logic [CNT_W-1:0] flush_cnt_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A stall overridden by a flush is not counted as a stall cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_p1 <= '0;
            flush_cnt_p1 <= '0;
        end else begin
            if (flush)
                flush_cnt_p1 <= sat_inc(flush_cnt_p1);
            else if (stall)
                stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign stall_cnt = stall_cnt_p1;
    assign flush_cnt = flush_cnt_p1;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
